// File: rtl/carfield_addr_map_unit.sv
// Runtime-programmable address map: a shadow window set written over a RegBus-style
// config port, committed atomically to the active map, and a one-stage pipelined region decoder.
module carfield_addr_map_unit #(
  parameter int unsigned NumRegions = 8,
  parameter int unsigned AddrWidth  = 64,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] DefaultBase   = '0,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] DefaultSize   = '0,
  parameter logic [NumRegions-1:0]                DefaultEnable = '0,
  localparam int unsigned IdxW = (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [9:0]           cfg_addr_i,
  input  logic [31:0]          cfg_wdata_i,
  output logic [31:0]          cfg_rdata_o,
  output logic                 cfg_ready_o,
  output logic                 cfg_error_o,
  input  logic                 dec_valid_i,
  output logic                 dec_ready_o,
  input  logic [AddrWidth-1:0] dec_addr_i,
  output logic                 dec_valid_o,
  input  logic                 dec_ready_i,
  output logic [IdxW-1:0]      dec_idx_o,
  output logic                 dec_hit_o
);

  localparam int unsigned GlobBase = 32 * NumRegions;
  localparam logic [9:0]  GlobAddr = 10'(GlobBase);

  typedef enum logic [1:0] {StIdle, StDrain, StSwap} state_e;
  state_e r_state, w_state_nxt;

  logic [NumRegions-1:0][AddrWidth-1:0] r_sh_base, r_sh_size, r_act_base, r_act_size;
  logic [NumRegions-1:0]                r_sh_en, r_act_en;
  logic                                 r_lock, r_overlap;
  logic                                 r_dec_valid, r_dec_hit;
  logic [IdxW-1:0]                      r_dec_idx;

  logic [IdxW-1:0] w_rsel;
  logic            w_in_regions, w_mapped, w_err;
  logic [9:0]      w_goff;
  logic [63:0]     w_cur_base, w_cur_size, w_new_val;
  logic            w_wr_base, w_wr_size, w_wr_ctrl, w_commit, w_lock_set;
  logic [31:0]     w_rdata;

  assign w_rsel       = cfg_addr_i[5 +: IdxW];
  assign w_in_regions = 32'(cfg_addr_i) < GlobBase;
  assign w_goff       = cfg_addr_i - GlobAddr;
  // 64-bit views so HI halves read as zero and drop writes when AddrWidth < 64
  assign w_cur_base   = 64'(r_sh_base[w_rsel]);
  assign w_cur_size   = 64'(r_sh_size[w_rsel]);

  always_comb begin
    w_rdata    = '0;
    w_err      = 1'b0;
    w_mapped   = 1'b0;
    w_wr_base  = 1'b0;
    w_wr_size  = 1'b0;
    w_wr_ctrl  = 1'b0;
    w_commit   = 1'b0;
    w_lock_set = 1'b0;
    w_new_val  = w_cur_base;
    if (cfg_req_i) begin
      if (cfg_addr_i[1:0] == 2'b00) begin
        if (w_in_regions) w_mapped = cfg_addr_i[4:0] <= 5'h10;
        else              w_mapped = w_goff <= 10'h8;
      end
      if (!w_mapped || (cfg_we_i && r_lock)) begin
        w_err = 1'b1;
      end else if (w_in_regions) begin
        case (cfg_addr_i[4:2])
          3'd0: begin
            w_rdata   = w_cur_base[31:0];
            w_new_val = {w_cur_base[63:32], cfg_wdata_i};
            w_wr_base = cfg_we_i;
          end
          3'd1: begin
            w_rdata   = w_cur_base[63:32];
            w_new_val = {cfg_wdata_i, w_cur_base[31:0]};
            w_wr_base = cfg_we_i;
          end
          3'd2: begin
            w_rdata   = w_cur_size[31:0];
            w_new_val = {w_cur_size[63:32], cfg_wdata_i};
            w_wr_size = cfg_we_i;
          end
          3'd3: begin
            w_rdata   = w_cur_size[63:32];
            w_new_val = {cfg_wdata_i, w_cur_size[31:0]};
            w_wr_size = cfg_we_i;
          end
          default: begin
            w_rdata   = {31'b0, r_sh_en[w_rsel]};
            w_wr_ctrl = cfg_we_i;
          end
        endcase
      end else begin
        case (w_goff[3:2])
          2'd0:    w_commit = cfg_we_i && cfg_wdata_i[0] && (r_state == StIdle);
          2'd1: begin
            w_rdata    = {31'b0, r_lock};
            w_lock_set = cfg_we_i && cfg_wdata_i[0];
          end
          default: w_rdata = {29'b0, r_overlap, r_lock, r_state != StIdle};
        endcase
      end
      if (cfg_we_i) w_rdata = '0;
    end
  end

  assign cfg_rdata_o = w_rdata;
  assign cfg_ready_o = cfg_req_i;
  assign cfg_error_o = w_err;

  logic [NumRegions-1:0][AddrWidth:0] w_act_end, w_sh_end;
  logic [NumRegions-1:0]              w_match;
  logic                               w_dec_hit, w_overlap;
  logic [IdxW-1:0]                    w_dec_idx;

  // Ends carry one extra bit so a window touching the top of the space does not wrap
  always_comb begin
    w_match   = '0;
    w_dec_hit = 1'b0;
    w_dec_idx = '0;
    for (int unsigned i = 0; i < NumRegions; i++) begin
      w_act_end[i] = {1'b0, r_act_base[i]} + {1'b0, r_act_size[i]};
      w_match[i]   = r_act_en[i] && (r_act_size[i] != '0) &&
                     (dec_addr_i >= r_act_base[i]) && ({1'b0, dec_addr_i} < w_act_end[i]);
    end
    for (int unsigned i = 0; i < NumRegions; i++) begin
      if (!w_dec_hit && w_match[i]) begin
        w_dec_hit = 1'b1;
        w_dec_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    w_overlap = 1'b0;
    for (int unsigned i = 0; i < NumRegions; i++) begin
      w_sh_end[i] = {1'b0, r_sh_base[i]} + {1'b0, r_sh_size[i]};
    end
    for (int unsigned i = 0; i < NumRegions; i++) begin
      for (int unsigned j = i + 1; j < NumRegions; j++) begin
        if (r_sh_en[i] && r_sh_en[j] && (r_sh_size[i] != '0) && (r_sh_size[j] != '0) &&
            ({1'b0, r_sh_base[i]} < w_sh_end[j]) && ({1'b0, r_sh_base[j]} < w_sh_end[i]))
          w_overlap = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_commit) w_state_nxt = StDrain;
      StDrain: if (!r_dec_valid || dec_ready_i) w_state_nxt = StSwap;
      StSwap:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  assign dec_ready_o = (!r_dec_valid || dec_ready_i) && (r_state == StIdle);
  assign dec_valid_o = r_dec_valid;
  assign dec_idx_o   = r_dec_idx;
  assign dec_hit_o   = r_dec_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_lock      <= 1'b0;
      r_overlap   <= 1'b0;
      r_sh_base   <= DefaultBase;
      r_sh_size   <= DefaultSize;
      r_sh_en     <= DefaultEnable;
      r_act_base  <= DefaultBase;
      r_act_size  <= DefaultSize;
      r_act_en    <= DefaultEnable;
      r_dec_valid <= 1'b0;
      r_dec_hit   <= 1'b0;
      r_dec_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_lock_set) r_lock <= 1'b1;
      if (w_wr_base)  r_sh_base[w_rsel] <= w_new_val[AddrWidth-1:0];
      if (w_wr_size)  r_sh_size[w_rsel] <= w_new_val[AddrWidth-1:0];
      if (w_wr_ctrl)  r_sh_en[w_rsel]   <= cfg_wdata_i[0];
      if (r_state == StSwap) begin
        r_act_base <= r_sh_base;
        r_act_size <= r_sh_size;
        r_act_en   <= r_sh_en;
        r_overlap  <= w_overlap;
      end
      if (dec_valid_i && dec_ready_o) begin
        r_dec_valid <= 1'b1;
        r_dec_hit   <= w_dec_hit;
        r_dec_idx   <= w_dec_idx;
      end else if (dec_ready_i) begin
        r_dec_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_carfield_addr_map_unit.sv
// Directed bench for carfield_addr_map_unit: reset map, commit timing, drain under
// backpressure, priority/overlap, top-of-space boundary, lock and reset mid-commit.
module tb_carfield_addr_map_unit;

  localparam logic [7:0][63:0] TbBase = {{5{64'h0}}, 64'h2000_1000, {2{64'h0}}};
  localparam logic [7:0][63:0] TbSize = {{5{64'h0}}, 64'h0000_9000, {2{64'h0}}};
  localparam logic [9:0] G = 10'h100;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_req_i = 1'b0, cfg_we_i = 1'b0;
  logic [9:0]  cfg_addr_i = '0;
  logic [31:0] cfg_wdata_i = '0;
  logic [31:0] cfg_rdata_o;
  logic        cfg_ready_o, cfg_error_o;
  logic        dec_valid_i = 1'b0, dec_ready_o;
  logic [63:0] dec_addr_i = '0;
  logic        dec_valid_o, dec_ready_i = 1'b1, dec_hit_o;
  logic [2:0]  dec_idx_o;

  int n_pass = 0;
  int n_total = 0;

  carfield_addr_map_unit #(
    .NumRegions   (8),
    .AddrWidth    (64),
    .DefaultBase  (TbBase),
    .DefaultSize  (TbSize),
    .DefaultEnable(8'b0000_0100)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cfg_req_i   (cfg_req_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_wdata_i (cfg_wdata_i),
    .cfg_rdata_o (cfg_rdata_o),
    .cfg_ready_o (cfg_ready_o),
    .cfg_error_o (cfg_error_o),
    .dec_valid_i (dec_valid_i),
    .dec_ready_o (dec_ready_o),
    .dec_addr_i  (dec_addr_i),
    .dec_valid_o (dec_valid_o),
    .dec_ready_i (dec_ready_i),
    .dec_idx_o   (dec_idx_o),
    .dec_hit_o   (dec_hit_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic exp_err, input string tag);
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
    #1 check({tag, ".err"}, 64'(cfg_error_o), 64'(exp_err));
    cyc();
    cfg_req_i = 1'b0; cfg_we_i = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] exp, input logic exp_err, input string tag);
    cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = a;
    #1;
    check({tag, ".rdata"}, 64'(cfg_rdata_o), 64'(exp));
    check({tag, ".err"}, 64'(cfg_error_o), 64'(exp_err));
    cyc();
    cfg_req_i = 1'b0;
  endtask

  task automatic dec(input logic [63:0] a, input logic hit, input logic [2:0] idx, input string tag);
    dec_valid_i = 1'b1; dec_addr_i = a;
    #1 check({tag, ".rdy"}, 64'(dec_ready_o), 64'd1);
    cyc();
    dec_valid_i = 1'b0;
    check({tag, ".valid"}, 64'(dec_valid_o), 64'd1);
    check({tag, ".hit"}, 64'(dec_hit_o), 64'(hit));
    check({tag, ".idx"}, 64'(dec_idx_o), 64'(idx));
  endtask

  task automatic commit_wait();
    wr(G, 32'h1, 1'b0, "commit");
    cyc();
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(); cyc(); cyc();
    rst_i = 1'b0;

    // Reset state and default map
    check("rst.valid", 64'(dec_valid_o), 64'd0);
    check("rst.hit", 64'(dec_hit_o), 64'd0);
    check("rst.idx", 64'(dec_idx_o), 64'd0);
    check("rst.err", 64'(cfg_error_o), 64'd0);
    check("rst.rdata", 64'(cfg_rdata_o), 64'd0);
    check("rst.dec_rdy", 64'(dec_ready_o), 64'd1);
    rd(G + 10'h8, 32'h0, 1'b0, "rst.status");
    rd(10'h40, 32'h2000_1000, 1'b0, "rst.base2");
    rd(10'h48, 32'h9000, 1'b0, "rst.size2");
    rd(10'h50, 32'h1, 1'b0, "rst.en2");
    dec(64'h2000_5000, 1'b1, 3'd2, "rst.hit2");
    dec(64'h2000_A000, 1'b0, 3'd0, "rst.end2");

    // Address errors and STATUS write
    rd(10'h014, 32'h0, 1'b1, "unmapped.gap");
    rd(10'h002, 32'h0, 1'b1, "unmapped.misalign");
    rd(G + 10'hC, 32'h0, 1'b1, "unmapped.glob");
    wr(10'h014, 32'h5, 1'b1, "unmapped.wr");
    wr(G + 10'h8, 32'h7, 1'b0, "status.wr");
    rd(G + 10'h8, 32'h0, 1'b0, "status.after_wr");

    // Program region 0 and commit with exact cycle timing
    wr(10'h00, 32'h4000_0000, 1'b0, "r0.blo");
    wr(10'h04, 32'h0, 1'b0, "r0.bhi");
    wr(10'h08, 32'h1000, 1'b0, "r0.slo");
    wr(10'h0C, 32'h0, 1'b0, "r0.shi");
    wr(10'h10, 32'h1, 1'b0, "r0.ctrl");
    dec(64'h4000_0800, 1'b0, 3'd0, "pre_commit");
    // cycle t: COMMIT write alongside a decode that must see the old map
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = G; cfg_wdata_i = 32'h1;
    dec_valid_i = 1'b1; dec_addr_i = 64'h4000_0800;
    #1;
    check("t.dec_rdy", 64'(dec_ready_o), 64'd1);
    check("t.err", 64'(cfg_error_o), 64'd0);
    cyc(); // t+1
    cfg_we_i = 1'b0; cfg_addr_i = G + 10'h8; dec_valid_i = 1'b0;
    check("t.old_map.valid", 64'(dec_valid_o), 64'd1);
    check("t.old_map.hit", 64'(dec_hit_o), 64'd0);
    #1;
    check("t1.dec_rdy", 64'(dec_ready_o), 64'd0);
    check("t1.status", 64'(cfg_rdata_o), 64'd1);
    cyc(); // t+2
    cfg_req_i = 1'b0; dec_valid_i = 1'b1;
    #1;
    check("t2.dec_rdy", 64'(dec_ready_o), 64'd0);
    check("t2.valid", 64'(dec_valid_o), 64'd0);
    cyc(); // t+3
    #1 check("t3.dec_rdy", 64'(dec_ready_o), 64'd1);
    cyc();
    dec_valid_i = 1'b0;
    check("t3.new_map.valid", 64'(dec_valid_o), 64'd1);
    check("t3.new_map.hit", 64'(dec_hit_o), 64'd1);
    check("t3.new_map.idx", 64'(dec_idx_o), 64'd0);
    rd(G + 10'h8, 32'h0, 1'b0, "t3.status");

    // Backpressure: the commit waits in DRAIN while a result is held
    dec_ready_i = 1'b0;
    dec(64'h2000_5000, 1'b1, 3'd2, "bp.dec");
    wr(G, 32'h1, 1'b0, "bp.commit");
    for (int i = 0; i < 3; i++) begin
      rd(G + 10'h8, 32'h1, 1'b0, "bp.drain");
      check("bp.hold.valid", 64'(dec_valid_o), 64'd1);
      check("bp.hold.idx", 64'(dec_idx_o), 64'd2);
      check("bp.hold.hit", 64'(dec_hit_o), 64'd1);
    end
    dec_ready_i = 1'b1;
    #1 check("bp.release.rdy", 64'(dec_ready_o), 64'd0);
    rd(G + 10'h8, 32'h1, 1'b0, "bp.release");
    check("bp.swap.valid", 64'(dec_valid_o), 64'd0);
    rd(G + 10'h8, 32'h1, 1'b0, "bp.swap");
    rd(G + 10'h8, 32'h0, 1'b0, "bp.idle");
    check("bp.idle.rdy", 64'(dec_ready_o), 64'd1);

    // Priority and overlap: regions 1 and 3 both cover 0x5000_0000
    wr(10'h20, 32'h5000_0000, 1'b0, "r1.blo");
    wr(10'h28, 32'h100, 1'b0, "r1.slo");
    wr(10'h30, 32'h1, 1'b0, "r1.ctrl");
    wr(10'h60, 32'h4FFF_FF00, 1'b0, "r3.blo");
    wr(10'h68, 32'h1000, 1'b0, "r3.slo");
    wr(10'h70, 32'h1, 1'b0, "r3.ctrl");
    commit_wait();
    dec(64'h5000_0000, 1'b1, 3'd1, "prio.low_wins");
    dec(64'h5000_0200, 1'b1, 3'd3, "prio.only3");
    rd(G + 10'h8, 32'h4, 1'b0, "prio.status");

    // Window ending exactly at the top of the 64-bit space
    wr(10'h80, 32'hFFFF_F000, 1'b0, "r4.blo");
    wr(10'h84, 32'hFFFF_FFFF, 1'b0, "r4.bhi");
    wr(10'h88, 32'h1000, 1'b0, "r4.slo");
    wr(10'h90, 32'h1, 1'b0, "r4.ctrl");
    rd(10'h84, 32'hFFFF_FFFF, 1'b0, "r4.bhi.rd");
    commit_wait();
    dec(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd4, "top.hit");
    dec(64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 3'd0, "top.below");
    wr(10'h88, 32'h0, 1'b0, "r4.size0");
    commit_wait();
    dec(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd0, "size0.top");
    dec(64'hFFFF_FFFF_FFFF_F000, 1'b0, 3'd0, "size0.base");

    // Lock: drop the overlap first, then writes and COMMIT are rejected
    wr(10'h70, 32'h0, 1'b0, "r3.disable");
    commit_wait();
    rd(G + 10'h8, 32'h0, 1'b0, "lock.pre_status");
    wr(G + 10'h4, 32'h1, 1'b0, "lock.set");
    rd(G + 10'h8, 32'h2, 1'b0, "lock.status");
    wr(10'h80, 32'h1234, 1'b1, "lock.base_wr");
    rd(10'h80, 32'hFFFF_F000, 1'b0, "lock.base_kept");
    wr(G, 32'h1, 1'b1, "lock.commit");
    rd(G + 10'h8, 32'h2, 1'b0, "lock.status2");

    // Reset in the middle of a commit restores the default maps and clears lock
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    rd(G + 10'h8, 32'h0, 1'b0, "rst2.status");
    wr(10'h00, 32'h4000_0000, 1'b0, "mid.blo");
    wr(10'h08, 32'h1000, 1'b0, "mid.slo");
    wr(10'h10, 32'h1, 1'b0, "mid.ctrl");
    wr(G, 32'h1, 1'b0, "mid.commit");
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    check("mid.valid", 64'(dec_valid_o), 64'd0);
    rd(G + 10'h8, 32'h0, 1'b0, "mid.status");
    rd(10'h00, 32'h0, 1'b0, "mid.shadow");
    dec(64'h4000_0800, 1'b0, 3'd0, "mid.r0_miss");
    dec(64'h2000_5000, 1'b1, 3'd2, "mid.default");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/carfield_addr_map_unit.md
# carfield_addr_map_unit

Runtime-programmable address map for the Carfield host domain. It holds `NumRegions` base/size/enable windows in a shadow register file, programmed over a RegBus-style config port, and commits them atomically to an active map. A pipelined decode port resolves incoming addresses to a region index against the active map. It replaces compile-time window constants so that an island's placement and enable can change after boot, with a sticky lock once firmware has settled the map.

## Interface
- `NumRegions`, 8: number of windows, 1..16.
- `AddrWidth`, 64: decoded address width.
- `DefaultBase`, all 0: `NumRegions` x `AddrWidth` reset bases.
- `DefaultSize`, all 0: `NumRegions` x `AddrWidth` reset sizes.
- `DefaultEnable`, all 0: `NumRegions`-bit reset enables.
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `cfg_req_i`  in  1  config access request.
- `cfg_we_i`  in  1  1 = write, 0 = read.
- `cfg_addr_i`  in  10  byte address, word-aligned.
- `cfg_wdata_i`  in  32  write data.
- `cfg_rdata_o`  out  32  read data, combinational, same cycle.
- `cfg_ready_o`  out  1  equals `cfg_req_i`.
- `cfg_error_o`  out  1  access rejected, valid with `cfg_ready_o`.
- `dec_valid_i` / `dec_ready_o`  in / out  1  decode request handshake.
- `dec_addr_i`  in  `AddrWidth`  address to decode.
- `dec_valid_o` / `dec_ready_i`  out / in  1  decode result handshake.
- `dec_idx_o`  out  $clog2(NumRegions)  matching region, 0 on miss.
- `dec_hit_o`  out  1  1 = some enabled region matched.

## Operation
- **Register map.** Region i sits at 0x20·i: BASE_LO 0x00, BASE_HI 0x04, SIZE_LO 0x08, SIZE_HI 0x0C, CTRL 0x10 (bit0 enable).
- **Global registers** sit at G = 0x20·NumRegions:
  - COMMIT G+0x0: writing bit0 = 1 starts a commit.
  - LOCK G+0x4: writing bit0 = 1 sets the lock; it is sticky until reset.
  - STATUS G+0x8, read-only: bit0 commit pending, bit1 locked, bit2 overlap.
- **Reads** return shadow values. Unused HI bits (AddrWidth < 64) read 0 and are write-ignored.
- **Errors.** `cfg_error_o` = 1 for an unmapped address, or for any write while locked; the access has no side effect and rdata = 0.
  - A write to STATUS is ignored with no error.
  - A write to COMMIT while a commit is pending is ignored with no error.
- **Match rule.** Region i matches when it is enabled, size ≠ 0, and base ≤ addr < base+size. The sum is computed at AddrWidth+1 bits, so no wrap-around. The lowest matching index wins.
- **Commit FSM** has three states:
  - IDLE: a COMMIT write moves to DRAIN.
  - DRAIN: `dec_ready_o` = 0. Move to SWAP once the output stage is empty, or is emptying this cycle (`dec_valid_o` & `dec_ready_i`).
  - SWAP: copy shadow to active in one cycle; STATUS.overlap is latched to 1 if any two enabled shadow regions intersect, else 0; return to IDLE.
- Shadow writes during DRAIN or SWAP are permitted. The values the shadow holds in the SWAP cycle are the ones committed.
- A commit requested before LOCK completes normally. While locked, COMMIT writes are rejected with error.

## Timing
- **Reset values.**
  - `dec_valid_o` = 0, `dec_idx_o` = 0, `dec_hit_o` = 0, `cfg_error_o` = 0, `cfg_rdata_o` = 0.
  - FSM in IDLE, lock = 0, overlap = 0.
  - Shadow and active both load the Default* parameters.
- **Config port:** single cycle, combinational response, no wait states.
- **Decode pipeline:** one register stage, latency 1.
  - `dec_ready_o` = (!`dec_valid_o` | `dec_ready_i`) & (FSM == IDLE).
  - Output holds stable while `dec_valid_o` & !`dec_ready_i`.
  - Full throughput of 1 decode per cycle when there is no backpressure.
- **Commit timing.** A COMMIT write at cycle t with an empty pipe gives: DRAIN at t+1, SWAP at t+2, IDLE at t+3. Decodes accepted at t+3 use the new map.
  - A decode accepted at cycle t itself uses the old map.
- **Reset mid-commit** returns to IDLE with Default* in both maps. Any in-flight result is dropped.

## Test plan
- **Reset map.** DefaultBase[2] = 0x2000_1000, DefaultSize[2] = 0x9000, DefaultEnable = 0b100. Decode 0x2000_5000 → hit = 1, idx = 2, one cycle after acceptance. Decode 0x2000_A000 → hit = 0, idx = 0.
- **Commit.** Program region 0 = [0x4000_0000, +0x1000), enable, then COMMIT. Before the commit, 0x4000_0800 misses. STATUS.bit0 = 1 during DRAIN. The same address hits idx 0 at t+3. `dec_ready_o` is low exactly in cycles t+1 and t+2.
- **Backpressure drain.** Hold `dec_ready_i` = 0 with one result pending, then COMMIT. The FSM stays in DRAIN and the output stays stable. Release `dec_ready_i` → SWAP next cycle.
- **Priority/overlap.** Regions 1 and 3 both cover 0x5000_0000, then commit. Decode returns idx 1, and STATUS = 0b100.
- **Boundaries.** A region with base 0xFFFF_FFFF_FFFF_F000 and size 0x1000 hits on 0xFFFF_FFFF_FFFF_FFFF. The same region with size 0 never hits.
- **Lock.** Write LOCK = 1, then attempt a BASE write and a COMMIT. Both return `cfg_error_o` = 1, the shadow is unchanged, and STATUS = 0b010.
